uart_bus_master: RTL and testbench

- Debug bridge that is the bus initiator driven from a serial link: it parses command frames received by a UART receiver, issues single-word reads and writes on bus_protocol_if as master, and returns status and read data through a UART transmitter.
- Sits between UartRxEn/UartTxEn (done/data/valid/busy handshakes) and any bus_protocol_if responder, e.g. AHBUart, memory or the register file.

---
 rtl/uart_bridge_pkg.sv | 36 +++
 rtl/uart_bridge_txq.sv | 87 ++++++++
 rtl/uart_bus_master.sv | 193 +++++++++++++++++++
 tb/tb_uart_bus_master.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART-to-bus debug bridge.
//   state_e      - main frame/bus sequencer states (debug-visible)
//   txq_state_e  - response transmit sequencer states (debug-visible)
//   ACK/NAK      - response status bytes
//   CMD_*        - default command bytes
//   byte counts  - address/data field length and response lengths
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_RESP = 3'd4,
        S_SEND = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        TQ_IDLE  = 2'd0,
        TQ_ISSUE = 2'd1,
        TQ_WAIT  = 2'd2
    } txq_state_e;

    localparam logic [7:0] ACK               = 8'h06;
    localparam logic [7:0] NAK               = 8'h15;
    localparam logic [7:0] CMD_WRITE_DEFAULT = 8'h57;
    localparam logic [7:0] CMD_READ_DEFAULT  = 8'h52;

    // Address and data fields are 4 bytes each; the 2-bit field counter
    // wraps after the last one.
    localparam logic [1:0] FIELD_LAST       = 2'd3;
    // Response lengths: status byte alone, or status plus 4 read-data bytes.
    localparam logic [2:0] RESP_BYTES_SHORT = 3'd1;
    localparam logic [2:0] RESP_BYTES_READ  = 3'd5;

endpackage

// File: rtl/uart_bridge_txq.sv
// Response transmit queue: a 5-byte shift register that feeds the UART
// transmitter one byte at a time, LSB byte of the payload first.
//   load/nbytes/payload - capture a response of nbytes (1..5) bytes; ignored unless idle
//   tx_busy/tx_done     - transmitter status and end-of-byte pulse
//   tx_data/tx_valid    - byte and one-cycle send request
//   idle                - no response in flight
//   dbg_state           - sequencer state
// Handshake: tx_valid pulses for one cycle only after a cycle with tx_busy=0;
// tx_data then stays put until the transmitter pulses tx_done.
module uart_bridge_txq
    import uart_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        nReset,
    input  logic        load,
    input  logic [2:0]  nbytes,
    input  logic [39:0] payload,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        idle,
    output logic [1:0]  dbg_state
);

    txq_state_e  state_q, state_d;
    logic [39:0] sreg_q, sreg_d;
    logic [2:0]  left_q, left_d;
    logic        tx_valid_q, tx_valid_d;

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        left_d     = left_q;
        tx_valid_d = 1'b0;
        case (state_q)
            TQ_IDLE: begin
                if (load) begin
                    sreg_d = payload;
                    left_d = nbytes;
                    // Request the first byte straight from the load cycle so
                    // the response costs no extra cycle when the line is free.
                    if (!tx_busy) begin
                        tx_valid_d = 1'b1;
                        state_d    = TQ_WAIT;
                    end else begin
                        state_d    = TQ_ISSUE;
                    end
                end
            end
            TQ_ISSUE: begin
                if (!tx_busy) begin
                    tx_valid_d = 1'b1;
                    state_d    = TQ_WAIT;
                end
            end
            TQ_WAIT: begin
                if (tx_done) begin
                    sreg_d = {8'h00, sreg_q[39:8]};
                    left_d = left_q - 3'd1;
                    state_d = (left_q == 3'd1) ? TQ_IDLE : TQ_ISSUE;
                end
            end
            default: state_d = TQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= TQ_IDLE;
            sreg_q     <= '0;
            left_q     <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            left_q     <= left_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_data   = sreg_q[7:0];
    assign tx_valid  = tx_valid_q;
    assign idle      = (state_q == TQ_IDLE);
    assign dbg_state = state_q;

endmodule

// File: rtl/uart_bus_master.sv
// UART debug bridge acting as bus master.
// Parses frames from the UART receiver:
//   write: CMD_WRITE a0 a1 a2 a3 d0 d1 d2 d3   -> reply ACK
//   read : CMD_READ  a0 a1 a2 a3               -> reply ACK r0 r1 r2 r3
// (little-endian fields); replies NAK alone on bus error, unknown command or
// receive framing error. A frame idle for TIMEOUT_CYCLES is silently dropped.
// Ports:
//   clk, nReset                  - clock, async active-low reset
//   rx_data/rx_done/rx_err       - receiver byte, byte strobe, framing error
//   tx_data/tx_valid/tx_busy/tx_done - transmitter interface
//   wen/ren/addr/wdata/strobe    - bus request (single word, all byte lanes)
//   rdata/error/request_stall    - bus response; transfer ends on first cycle with request_stall=0
//   dbg_state/dbg_txq_state      - sequencer states
module uart_bus_master
    import uart_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  CMD_WRITE      = CMD_WRITE_DEFAULT,
    parameter logic [7:0]  CMD_READ       = CMD_READ_DEFAULT
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic        rx_err,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic        wen,
    output logic        ren,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  strobe,
    input  logic [31:0] rdata,
    input  logic        error,
    input  logic        request_stall,
    output logic [2:0]  dbg_state,
    output logic [1:0]  dbg_txq_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e         state_q, state_d;
    logic           is_write_q, is_write_d;
    logic           nak_q, nak_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [TW-1:0]  to_q, to_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           wen_q, wen_d;
    logic           ren_q, ren_d;

    logic           txq_load;
    logic [2:0]     txq_nbytes;
    logic [39:0]    txq_payload;
    logic           txq_idle;

    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        nak_d       = nak_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        wen_d       = wen_q;
        ren_d       = ren_q;
        txq_load    = 1'b0;
        txq_nbytes  = RESP_BYTES_SHORT;
        txq_payload = {32'h0, ACK};
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                to_d  = '0;
                // rx_err outranks a simultaneous rx_done.
                if (rx_err) begin
                    nak_d   = 1'b1;
                    state_d = S_RESP;
                end else if (rx_done) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        is_write_d = (rx_data == CMD_WRITE);
                        nak_d      = 1'b0;
                        state_d    = S_ADDR;
                    end else begin
                        nak_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (rx_err) begin
                    nak_d   = 1'b1;
                    state_d = S_RESP;
                end else if (rx_done) begin
                    to_d  = '0;
                    cnt_d = cnt_q + 2'd1;
                    // Shift in from the top so byte 0 ends up in bits [7:0].
                    if (state_q == S_ADDR) addr_d  = {rx_data, addr_q[31:8]};
                    else                   wdata_d = {rx_data, wdata_q[31:8]};
                    if (cnt_q == FIELD_LAST) begin
                        if (state_q == S_ADDR && is_write_q) begin
                            state_d = S_DATA;
                        end else begin
                            // Request goes out on the first BUS cycle.
                            state_d = S_BUS;
                            wen_d   = is_write_q;
                            ren_d   = !is_write_q;
                        end
                    end
                end else if (to_q == TW'(TIMEOUT_CYCLES)) begin
                    to_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_BUS: begin
                if (!request_stall) begin
                    wen_d   = 1'b0;
                    ren_d   = 1'b0;
                    rdata_d = rdata;
                    nak_d   = error;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                txq_load = 1'b1;
                if (nak_q) begin
                    txq_payload = {32'h0, NAK};
                end else if (!is_write_q) begin
                    txq_nbytes  = RESP_BYTES_READ;
                    txq_payload = {rdata_q, ACK};
                end
                state_d = S_SEND;
            end
            S_SEND: begin
                if (txq_idle) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            nak_q      <= 1'b0;
            cnt_q      <= '0;
            to_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            nak_q      <= nak_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wen_q      <= wen_d;
            ren_q      <= ren_d;
        end
    end

    uart_bridge_txq u_txq (
        .clk       (clk),
        .nReset    (nReset),
        .load      (txq_load),
        .nbytes    (txq_nbytes),
        .payload   (txq_payload),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .idle      (txq_idle),
        .dbg_state (dbg_txq_state)
    );

    assign wen       = wen_q;
    assign ren       = ren_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign strobe    = 4'hF;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_bus_master.sv
module tb_uart_bus_master;

    localparam int TO = 20;

    logic        clk;
    logic        nReset;
    logic [7:0]  rx_data;
    logic        rx_done, rx_err;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_busy, tx_done;
    logic        wen, ren;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  strobe;
    logic        error, request_stall;
    logic [2:0]  dbg_state;
    logic [1:0]  dbg_txq_state;

    uart_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .nReset(nReset),
        .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy), .tx_done(tx_done),
        .wen(wen), .ren(ren), .addr(addr), .wdata(wdata), .strobe(strobe),
        .rdata(rdata), .error(error), .request_stall(request_stall),
        .dbg_state(dbg_state), .dbg_txq_state(dbg_txq_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        int          len;
    } bus_op_t;

    bus_op_t     exp_bus[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_tx[$];
    logic [7:0]  fb[$];

    // responder / transmitter models
    int          stall_n = 0;
    logic [31:0] resp_rdata = 32'h0;
    logic        resp_err = 1'b0;
    int          req_cyc = 0;
    bit          uart_busy = 0;
    bit          force_busy = 0;
    int          busy_cnt = 0;

    // monitor state
    int          cyc = 0;
    int          last_rx_cyc = 0;
    int          lat = -1;
    bit          first_tx_pending = 0;
    bit          in_req = 0;
    int          req_len = 0;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] last_addr, last_wdata;
    int          last_len = 0;
    int          bus_count = 0;
    bit          hold_active = 0;
    logic [7:0]  hold_data;
    logic        prev_busy = 1'b0;

    // Responder and UART transmitter, reacting shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        tx_done = 1'b0;
        error   = 1'b0;
        rdata   = 32'hBAD0_BAD0;
        if (!nReset) begin
            req_cyc = 0; request_stall = 1'b0; uart_busy = 0; busy_cnt = 0;
        end else begin
            if (wen || ren) begin
                request_stall = (req_cyc < stall_n);
                if (!request_stall) begin
                    rdata = resp_rdata;
                    error = resp_err;
                end
                req_cyc++;
            end else begin
                req_cyc = 0;
                request_stall = 1'b0;
            end
            if (tx_valid) begin
                uart_busy = 1; busy_cnt = 4;
            end else if (uart_busy) begin
                if (busy_cnt == 0) begin uart_busy = 0; tx_done = 1'b1; end
                else busy_cnt--;
            end
        end
        tx_busy = uart_busy | force_busy;
    end

    // Compare process: checks DUT outputs against the expectation queues.
    always @(negedge clk) begin
        bus_op_t op;
        cyc++;
        if (nReset) begin
            if (rx_done && !rx_err) last_rx_cyc = cyc;
            chk("strobe", strobe, 4'hF);
            chk("wen_ren_exclusive", wen & ren, 0);
            if (wen || ren) begin
                if (in_req) begin
                    chk("addr_stable", addr, req_addr);
                    chk("wdata_stable", wdata, req_wdata);
                end else begin
                    in_req = 1; req_len = 0; req_addr = addr; req_wdata = wdata;
                end
                req_len++;
                if (!request_stall) begin
                    in_req = 0;
                    chk("bus_op_expected", exp_bus.size() != 0, 1);
                    if (exp_bus.size() != 0) begin
                        op = exp_bus.pop_front();
                        chk("bus_kind_wen", wen, op.wr);
                        chk("bus_addr", addr, op.a);
                        if (op.wr) chk("bus_wdata", wdata, op.d);
                        chk("bus_len", req_len, op.len);
                    end
                    last_addr = addr; last_wdata = wdata; last_len = req_len;
                    bus_count++;
                end
            end else begin
                in_req = 0;
            end
            if (tx_valid) begin
                chk("tx_valid_after_busy", prev_busy, 0);
                got_tx.push_back(tx_data);
                if (first_tx_pending) begin
                    lat = cyc - last_rx_cyc;
                    first_tx_pending = 0;
                end
                chk("tx_byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("tx_byte", tx_data, exp_q.pop_front());
                hold_active = 1; hold_data = tx_data;
            end else if (hold_active) begin
                chk("tx_data_hold", tx_data, hold_data);
            end
            if (tx_done) hold_active = 0;
            prev_busy = tx_busy;
        end else begin
            in_req = 0; hold_active = 0; prev_busy = 1'b0;
        end
    end

    // ---------------- model: expectations from frame contents ----------------
    task automatic model_frame(input int err_idx);
        bus_op_t op;
        int n;
        n = fb.size();
        if (err_idx >= 0 && err_idx < n) begin
            exp_q.push_back(8'h15);
            return;
        end
        if (fb[0] == 8'h57) begin
            if (n < 9) return;
            op.wr = 1; op.a = {fb[4], fb[3], fb[2], fb[1]};
            op.d = {fb[8], fb[7], fb[6], fb[5]}; op.len = stall_n + 1;
            exp_bus.push_back(op);
            exp_q.push_back(8'h06);
        end else if (fb[0] == 8'h52) begin
            if (n < 5) return;
            op.wr = 0; op.a = {fb[4], fb[3], fb[2], fb[1]}; op.d = 32'h0; op.len = stall_n + 1;
            exp_bus.push_back(op);
            if (resp_err) exp_q.push_back(8'h15);
            else begin
                exp_q.push_back(8'h06);
                for (int k = 0; k < 4; k++) exp_q.push_back(resp_rdata[8*k +: 8]);
            end
        end else begin
            exp_q.push_back(8'h15);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input bit err, input int gap);
        repeat (gap) @(posedge clk);
        @(posedge clk); #2;
        rx_data = b; rx_done = 1'b1; rx_err = err;
        @(posedge clk); #2;
        rx_done = 1'b0; rx_err = 1'b0;
    endtask

    task automatic run_frame(input int err_idx, input int gap);
        model_frame(err_idx);
        for (int i = 0; i < fb.size(); i++) begin
            send_byte(fb[i], (i == err_idx), gap);
            if (i == err_idx) break;
        end
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_bus.size() != 0 || dbg_state != 3'd0 || uart_busy) && n < 3000) begin
            @(posedge clk); n++;
        end
        chk({name, "_completed"}, (n < 3000), 1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        nReset = 1'b0; rx_data = 8'h0; rx_done = 1'b0; rx_err = 1'b0;
        tx_busy = 1'b0; tx_done = 1'b0; rdata = 32'h0; error = 1'b0; request_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_wen", wen, 0);
        chk("rst_ren", ren, 0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_strobe", strobe, 4'hF);
        chk("rst_state", dbg_state, 3'd0);
        @(posedge clk); #2; nReset = 1'b1;
        repeat (2) @(posedge clk);

        // 1: plain write, minimum latency
        got_tx.delete(); stall_n = 0; first_tx_pending = 1;
        fb = '{8'h57, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_frame(-1, 0);
        wait_quiet("write1");
        chk("w1_addr", last_addr, 32'h0000_1000);
        chk("w1_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("w1_len", last_len, 1);
        chk("w1_tx_count", got_tx.size(), 1);
        if (got_tx.size() == 1) chk("w1_tx0", got_tx[0], 8'h06);
        chk("w1_latency", lat, 3);

        // 2: read with 3 stall cycles
        got_tx.delete(); stall_n = 3; resp_rdata = 32'h1234_5678;
        fb = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h00};
        run_frame(-1, 0);
        wait_quiet("read1");
        chk("r1_addr", last_addr, 32'h0000_0004);
        chk("r1_ren_len", last_len, 4);
        chk("r1_tx_count", got_tx.size(), 5);
        if (got_tx.size() == 5)
            chk("r1_tx_bytes", {got_tx[0], got_tx[1], got_tx[2], got_tx[3], got_tx[4]}, 40'h06_78_56_34_12);

        // 3: read with bus error, then a valid write
        got_tx.delete(); stall_n = 0; resp_err = 1'b1; resp_rdata = 32'hCAFE_F00D;
        fb = '{8'h52, 8'h40, 8'h30, 8'h20, 8'h10};
        run_frame(-1, 0);
        wait_quiet("read_err");
        chk("re_tx_count", got_tx.size(), 1);
        if (got_tx.size() == 1) chk("re_tx0", got_tx[0], 8'h15);
        resp_err = 1'b0; stall_n = 1;
        fb = '{8'h57, 8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'h02, 8'h03, 8'h04};
        run_frame(-1, 0);
        wait_quiet("write_after_err");
        chk("wae_wdata", last_wdata, 32'h0403_0201);

        // 4: unknown command, and rx_err on the 3rd address byte
        got_tx.delete(); stall_n = 0; n = bus_count;
        fb = '{8'h41};
        run_frame(-1, 0);
        wait_quiet("unknown_cmd");
        fb = '{8'h52, 8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(3, 0);
        wait_quiet("rx_err_addr");
        chk("nak_no_bus", bus_count, n);
        chk("nak_tx_count", got_tx.size(), 2);
        if (got_tx.size() == 2) chk("nak_tx", {got_tx[0], got_tx[1]}, 16'h1515);

        // 5: slow but in-time bytes, then a frame that times out after 5 bytes
        got_tx.delete();
        fb = '{8'h57, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(-1, TO - 4);
        wait_quiet("slow_write");
        chk("slow_wdata", last_wdata, 32'h4433_2211);
        got_tx.delete(); n = bus_count;
        fb = '{8'h57, 8'h00, 8'h20, 8'h00, 8'h00};
        run_frame(-1, 0);
        repeat (TO - 5) @(posedge clk);
        #1;
        chk("to_still_data", dbg_state, 3'd2);
        repeat (10) @(posedge clk);
        #1;
        chk("to_back_idle", dbg_state, 3'd0);
        chk("to_no_tx", got_tx.size(), 0);
        chk("to_no_bus", bus_count, n);
        fb = '{8'h52, 8'h00, 8'h20, 8'h00, 8'h00};
        resp_rdata = 32'hA5A5_0001;
        run_frame(-1, 0);
        wait_quiet("after_timeout");
        chk("ato_tx_count", got_tx.size(), 5);

        // 6: byte during BUS is dropped
        got_tx.delete(); stall_n = 5; resp_rdata = 32'h0BAD_CAFE;
        fb = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
        run_frame(-1, 0);
        send_byte(8'h57, 1'b0, 0);
        wait_quiet("drop_in_bus");
        stall_n = 0;
        fb = '{8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
        run_frame(-1, 0);
        wait_quiet("after_drop");
        chk("drop_tx_count", got_tx.size(), 6);

        // 7: transmitter busy for 50 cycles
        got_tx.delete(); force_busy = 1;
        fb = '{8'h57, 8'h30, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        run_frame(-1, 0);
        repeat (50) @(posedge clk);
        #1;
        chk("busy_deferred", got_tx.size(), 0);
        @(posedge clk); #2; force_busy = 0;
        wait_quiet("busy_release");
        chk("busy_tx_count", got_tx.size(), 1);

        // 8: reset in the middle of a bus transfer
        stall_n = 1000;
        fb = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < fb.size(); i++) send_byte(fb[i], 1'b0, 0);
        n = 0;
        while (!ren && n < 50) begin @(negedge clk); n++; end
        chk("mid_bus_ren_seen", ren, 1);
        @(posedge clk); #2; nReset = 1'b0; #1;
        chk("mid_rst_ren", ren, 0);
        chk("mid_rst_wen", wen, 0);
        chk("mid_rst_addr", addr, 32'h0);
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_state", dbg_state, 3'd0);
        repeat (2) @(posedge clk);
        #2; stall_n = 0; nReset = 1'b1;
        got_tx.delete();
        fb = '{8'h57, 8'h00, 8'h00, 8'h01, 8'h00, 8'h99, 8'h00, 8'h00, 8'h00};
        run_frame(-1, 0);
        wait_quiet("after_reset");
        chk("ar_addr", last_addr, 32'h0001_0000);
        chk("ar_tx_count", got_tx.size(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
